si_inv_unit: RTL and testbench

Multi-cycle inverse companion to the special-instruction ALU: given a result `VAL`, the second operand `RT`, the rotate amount and the op code, it recovers the original `RS` operand. It sits beside the SI ALU in the execute stage and serves decrypt-direction special instructions. It uses true 32-bit rotates, rotating one bit per cycle by default. Start/busy/done handshake to the pipeline control.

---
 rtl/si_inv_unit.sv | 192 +++++++++++++++++++
 tb/tb_si_inv_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/si_inv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : si_inv_unit
//  Description : Multi-cycle inverse of the special-instruction ALU ops 5..8.
//                Recovers RS from the forward result VAL, operand RT and the
//                rotate amount. The rotate is bit-serial (one bit per cycle)
//                unless SI_INV_FAST_ROT_EN is defined, in which case a barrel
//                rotator completes the rotate phase in a single cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module si_inv_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [3:0]  ALU_CNTRL,
    input  logic [31:0] VAL,
    input  logic [31:0] RT,
    input  logic [3:0]  ROT_AM,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [31:0] RS_OUT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_ROT  = 2'd2,
        ST_POST = 2'd3
    } state_t;

    localparam logic [3:0] c_OP_XOR_ROTL = 4'd5;
    localparam logic [3:0] c_OP_ROTR_XOR = 4'd6;
    localparam logic [3:0] c_OP_ROTL_ADD = 4'd7;
    localparam logic [3:0] c_OP_SUB_ROTR = 4'd8;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_op;
    logic [31:0] r_acc;
    logic [31:0] r_rt;
    logic [3:0]  r_cnt;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_rs;

    logic        w_op_valid;
    logic        w_rot_right;
    logic [31:0] w_pre_val;
    logic [31:0] w_post_val;
    logic [31:0] w_rot_next;

    // Forward ops that rotated left are undone by rotating right, and vice versa.
    assign w_op_valid  = (r_op >= c_OP_XOR_ROTL) && (r_op <= c_OP_SUB_ROTR);
    assign w_rot_right = (r_op == c_OP_XOR_ROTL) || (r_op == c_OP_ROTL_ADD);

`ifdef SI_INV_FAST_ROT_EN
    logic [63:0] w_dbl;
    logic [63:0] w_dbl_r;
    logic [63:0] w_dbl_l;

    // Barrel rotate of the accumulator by the full remaining count.
    assign w_dbl      = {r_acc, r_acc};
    assign w_dbl_r    = w_dbl >> r_cnt;
    assign w_dbl_l    = w_dbl << r_cnt;
    assign w_rot_next = w_rot_right ? w_dbl_r[31:0] : w_dbl_l[63:32];
`else
    // Single-bit rotate of the accumulator.
    assign w_rot_next = w_rot_right ? {r_acc[0], r_acc[31:1]}
                                    : {r_acc[30:0], r_acc[31]};
`endif

    // Undo the operation the forward instruction applied after its rotate.
    always_comb begin
        w_pre_val = r_acc;
        case (r_op)
            c_OP_ROTR_XOR: w_pre_val = r_acc ^ r_rt;
            c_OP_ROTL_ADD: w_pre_val = r_acc - r_rt;
            default:       w_pre_val = r_acc;
        endcase
    end

    // Undo the operation the forward instruction applied before its rotate.
    always_comb begin
        w_post_val = r_acc;
        case (r_op)
            c_OP_XOR_ROTL: w_post_val = r_acc ^ r_rt;
            c_OP_SUB_ROTR: w_post_val = r_acc + r_rt;
            default:       w_post_val = r_acc;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the rotate phase is skipped for n=0 and invalid ops.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_state_nxt = ST_PRE;
                end
            end
            ST_PRE: begin
                if (!w_op_valid || (r_cnt == 4'd0)) begin
                    w_state_nxt = ST_POST;
                end else begin
                    w_state_nxt = ST_ROT;
                end
            end
            ST_ROT: begin
`ifdef SI_INV_FAST_ROT_EN
                w_state_nxt = ST_POST;
`else
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_POST;
                end
`endif
            end
            ST_POST: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand latching, accumulator processing and result registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_op   <= 4'd0;
            r_acc  <= 32'd0;
            r_rt   <= 32'd0;
            r_cnt  <= 4'd0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_rs   <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_op  <= ALU_CNTRL;
                        r_acc <= VAL;
                        r_rt  <= RT;
                        r_cnt <= ROT_AM;
                        r_err <= 1'b0;
                    end
                end
                ST_PRE: begin
                    r_acc <= w_pre_val;
                end
                ST_ROT: begin
                    r_acc <= w_rot_next;
`ifdef SI_INV_FAST_ROT_EN
                    r_cnt <= 4'd0;
`else
                    r_cnt <= r_cnt - 4'd1;
`endif
                end
                ST_POST: begin
                    r_done <= 1'b1;
                    if (w_op_valid) begin
                        r_rs  <= w_post_val;
                        r_err <= 1'b0;
                    end else begin
                        r_rs  <= 32'd0;
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY   = (r_state != ST_IDLE);
    assign DONE   = r_done;
    assign ERR    = r_err;
    assign RS_OUT = r_rs;

endmodule
`default_nettype wire

// File: tb/tb_si_inv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_si_inv_unit
//  Description : Directed self-checking bench for si_inv_unit. Honors
//                SI_INV_FAST_ROT_EN for the expected latencies.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_si_inv_unit;

`ifdef SI_INV_FAST_ROT_EN
    localparam bit c_FAST = 1'b1;
`else
    localparam bit c_FAST = 1'b0;
`endif

    logic        CLK;
    logic        RST;
    logic        START;
    logic [3:0]  ALU_CNTRL;
    logic [31:0] VAL;
    logic [31:0] RT;
    logic [3:0]  ROT_AM;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [31:0] RS_OUT;

    int n_total;
    int n_pass;

    si_inv_unit u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .ALU_CNTRL (ALU_CNTRL),
        .VAL       (VAL),
        .RT        (RT),
        .ROT_AM    (ROT_AM),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .RS_OUT    (RS_OUT)
    );

    // 100 MHz clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int exp_lat(input logic [3:0] op, input logic [3:0] n);
        if (op < 4'd5 || op > 4'd8 || n == 4'd0) return 2;
        if (c_FAST) return 3;
        return int'(n) + 2;
    endfunction

    // Issue one op at the next edge (k), then wait for DONE and check it.
    // With hold set, START stays high for the whole busy period.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] val,
                          input logic [31:0] rt, input logic [3:0] n,
                          input logic [31:0] exp_rs, input logic exp_err, input bit hold);
        int cyc;
        ALU_CNTRL = op;
        VAL       = val;
        RT        = rt;
        ROT_AM    = n;
        START     = 1'b1;
        @(posedge CLK); #1;
        if (!hold) START = 1'b0;
        ALU_CNTRL = 4'hF;
        VAL       = 32'hDEADBEEF;
        RT        = 32'hCAFEF00D;
        ROT_AM    = 4'hF;
        check({tag, "_busy"}, {31'd0, BUSY}, 32'd1);
        check({tag, "_err_clr"}, {31'd0, ERR}, 32'd0);
        cyc = 0;
        while (cyc < 40) begin
            @(posedge CLK); #1;
            cyc++;
            if (DONE) break;
        end
        START = 1'b0;
        check({tag, "_lat"}, cyc, exp_lat(op, n));
        check({tag, "_rs"}, RS_OUT, exp_rs);
        check({tag, "_err"}, {31'd0, ERR}, {31'd0, exp_err});
        check({tag, "_busy_done"}, {31'd0, BUSY}, 32'd0);
    endtask

    // Count DONE pulses over a window where none are expected.
    task automatic quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLK); #1;
            if (DONE) seen++;
        end
        check({tag, "_no_done"}, seen, 0);
        check({tag, "_idle"}, {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        RST       = 1'b1;
        START     = 1'b0;
        ALU_CNTRL = 4'd0;
        VAL       = 32'd0;
        RT        = 32'd0;
        ROT_AM    = 4'd0;

        #2;
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_done", {31'd0, DONE}, 32'd0);
        check("rst_err",  {31'd0, ERR},  32'd0);
        check("rst_rs",   RS_OUT,        32'd0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;

        run_op("op5", 4'd5, 32'h000000F0, 32'h00000001, 4'd4,  32'h0000000E, 1'b0, 1'b0);
        run_op("op6", 4'd6, 32'hA5A5A5A5, 32'hFFFFFFFF, 4'd0,  32'h5A5A5A5A, 1'b0, 1'b0);
        run_op("op7", 4'd7, 32'h00000010, 32'h00000020, 4'd1,  32'h7FFFFFF8, 1'b0, 1'b0);
        run_op("op8", 4'd8, 32'h80000001, 32'h00000001, 4'd15, 32'h0000C001, 1'b0, 1'b1);
        quiet("op8_hold", 20);

        run_op("op3", 4'd3, 32'h13572468, 32'h2468ACE0, 4'd9,  32'h00000000, 1'b1, 1'b0);
        run_op("op5b", 4'd5, 32'h00000003, 32'h00000010, 4'd0, 32'h00000013, 1'b0, 1'b0);

        // Abort an n=15 op in the middle of its rotate phase.
        ALU_CNTRL = 4'd8;
        VAL       = 32'h0F0F0F0F;
        RT        = 32'h00000003;
        ROT_AM    = 4'd15;
        START     = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
        end
        check("abort_busy_pre", {31'd0, BUSY}, 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("abort_busy", {31'd0, BUSY}, 32'd0);
        check("abort_done", {31'd0, DONE}, 32'd0);
        check("abort_err",  {31'd0, ERR},  32'd0);
        check("abort_rs",   RS_OUT,        32'd0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;
        quiet("abort", 20);

        run_op("op6b", 4'd6, 32'h12345678, 32'h0F0F0F0F, 4'd4, 32'hD3B59771, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
